// File: rtl/fetch_stage_if.sv
// Bus bundle for fetch_stage: control inputs, instruction-memory port,
// IF/ID register outputs and status/performance outputs.
// master = the fetch stage, slave = its environment (hazard unit, memory, decode).
interface fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic              Stall;
    logic              Redirect;
    logic [ADDR_W-1:0] PCNext;
    logic              EndFlag;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       InstrD;
    logic [ADDR_W-1:0] PCD;
    logic              ValidD;
    logic              Busy;
    logic              Done;
    logic [31:0]       FetchCnt;
    logic [31:0]       StallCnt;

    modport master (
        input  start, Stall, Redirect, PCNext, EndFlag, imem_rdata,
        output imem_en, imem_addr, InstrD, PCD, ValidD, Busy, Done,
               FetchCnt, StallCnt
    );

    modport slave (
        output start, Stall, Redirect, PCNext, EndFlag, imem_rdata,
        input  imem_en, imem_addr, InstrD, PCD, ValidD, Busy, Done,
               FetchCnt, StallCnt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues reads to a synchronous
// instruction memory (1-cycle read latency) and registers returned words into
// the IF/ID register. A 1-entry skid buffer catches a response that lands while
// decode is stalled, so fetch throughput is kept across stalls.
// Optional feature macro: FETCH_PERF_CNT_EN (delivered-instruction and stall
// cycle counters); when undefined FetchCnt/StallCnt are tied to 0.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              skid_vld_q, skid_vld_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pcd_q, pcd_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              issue;

    // Next-state, PC, pending/skid and IF/ID register logic.
    // Priority inside RUN: EndFlag > Redirect > Stall > normal fetch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
        skid_vld_d   = skid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        instr_d      = instr_q;
        pcd_d        = pcd_q;
        valid_d      = valid_q;
        issue        = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_d    = RUN;
                    pc_d       = RESET_PC;
                    pend_d     = 1'b0;
                    skid_vld_d = 1'b0;
                    valid_d    = 1'b0;
                end
            end
            RUN: begin
                if (bus.EndFlag) begin
                    state_d    = HALT;
                    pend_d     = 1'b0;
                    skid_vld_d = 1'b0;
                    valid_d    = 1'b0;
                end else if (bus.Redirect) begin
                    pc_d       = bus.PCNext;
                    pend_d     = 1'b0;
                    skid_vld_d = 1'b0;
                    valid_d    = 1'b0;
                end else if (bus.Stall) begin
                    // Park an in-flight response; IF/ID holds.
                    if (pend_q) begin
                        skid_vld_d   = 1'b1;
                        skid_instr_d = bus.imem_rdata;
                        skid_pc_d    = pend_pc_q;
                        pend_d       = 1'b0;
                    end
                end else begin
                    issue     = 1'b1;
                    pc_d      = pc_q + ADDR_W'(4);
                    pend_d    = 1'b1;
                    pend_pc_d = pc_q;
                    // Skid entry is older than anything pending, so it goes first.
                    if (skid_vld_q) begin
                        instr_d    = skid_instr_q;
                        pcd_d      = skid_pc_q;
                        valid_d    = 1'b1;
                        skid_vld_d = 1'b0;
                    end else if (pend_q) begin
                        instr_d = bus.imem_rdata;
                        pcd_d   = pend_pc_q;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == HALT);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            pend_q       <= 1'b0;
            pend_pc_q    <= '0;
            skid_vld_q   <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            instr_q      <= '0;
            pcd_q        <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            skid_vld_q   <= skid_vld_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc_q;
    assign bus.InstrD    = instr_q;
    assign bus.PCD       = pcd_q;
    assign bus.ValidD    = valid_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        deliver;
    logic        clear_cnt;

    assign deliver   = (state_q == RUN) && !bus.EndFlag && !bus.Redirect &&
                       !bus.Stall && (skid_vld_q || pend_q);
    assign clear_cnt = (state_q != RUN) && bus.start;

    // Performance counters: wrap naturally, cleared when fetch (re)starts.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (clear_cnt) begin
            fetch_cnt_d = '0;
            stall_cnt_d = '0;
        end else begin
            if (deliver)                          fetch_cnt_d = fetch_cnt_q + 32'd1;
            if ((state_q == RUN) && bus.Stall)    stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.FetchCnt = fetch_cnt_q;
    assign bus.StallCnt = stall_cnt_q;
`else
    assign bus.FetchCnt = '0;
    assign bus.StallCnt = '0;
`endif
endmodule
